// File: rtl/fp_mult_arb_pkg.sv
// fp_mult_arb_pkg: shared widths, FSM encoding and operand/response records for fp_mult_arbiter
package fp_mult_arb_pkg;
    localparam int FP_W    = 32;
    localparam int NUM_REQ = 2;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        HOLD = 2'd2
    } state_e;
    typedef struct packed {
        logic            id;
        logic [FP_W-1:0] a;
        logic [FP_W-1:0] b;
    } operand_t;
    typedef struct packed {
        logic            id;
        logic            ovf;
        logic            unf;
        logic [FP_W-1:0] result;
    } response_t;
endpackage

// File: rtl/fp_mult_arbiter_mul.sv
// fp_mult_arbiter_mul: combinational IEEE-754 single multiply, round-to-nearest-even
// Ports: data1, data2 (operands) -> result, overflow, underflow.
// Subnormal inputs are treated as zero and subnormal results flush to signed zero (underflow set).
// NaN inputs propagate quieted; Inf x 0 yields the default quiet NaN.
module fp_mult_arbiter_mul
    import fp_mult_arb_pkg::*;
(
    input  logic [FP_W-1:0] data1,
    input  logic [FP_W-1:0] data2,
    output logic [FP_W-1:0] result,
    output logic            overflow,
    output logic            underflow
);
    logic              sgn, norm, grd, stk, rnd;
    logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [7:0]        ea, eb;
    logic [22:0]       fa, fb, man;
    logic [47:0]       prod;
    logic [23:0]       man_r;
    logic signed [9:0] exp_n, exp_r;
    always_comb begin
        sgn    = data1[31] ^ data2[31];
        ea     = data1[30:23];
        eb     = data2[30:23];
        fa     = data1[22:0];
        fb     = data2[22:0];
        a_nan  = (&ea) & (|fa);
        b_nan  = (&eb) & (|fb);
        a_inf  = (&ea) & ~(|fa);
        b_inf  = (&eb) & ~(|fb);
        a_zero = ~(|ea);
        b_zero = ~(|eb);
        prod   = {24'd0, 1'b1, fa} * {24'd0, 1'b1, fb};
        norm   = prod[47];
        man    = norm ? prod[46:24] : prod[45:23];
        grd    = norm ? prod[23] : prod[22];
        stk    = norm ? |prod[22:0] : |prod[21:0];
        rnd    = grd & (stk | man[0]);
        man_r  = {1'b0, man} + {23'd0, rnd};
        exp_n  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127 + $signed({9'd0, norm});
        // a rounding carry turns 1.111.. into 10.000.., bumping the exponent
        exp_r  = exp_n + $signed({9'd0, man_r[23]});
        overflow  = 1'b0;
        underflow = 1'b0;
        if (a_nan | b_nan | (a_inf & b_zero) | (a_zero & b_inf))
            result = a_nan ? (data1 | 32'h0040_0000) : b_nan ? (data2 | 32'h0040_0000) : 32'h7FC0_0000;
        else if (a_inf | b_inf)
            result = {sgn, 8'hFF, 23'd0};
        else if (a_zero | b_zero)
            result = {sgn, 31'd0};
        else if (exp_r > 10'sd254) begin
            result   = {sgn, 8'hFF, 23'd0};
            overflow = 1'b1;
        end else if (exp_r < 10'sd1) begin
            result    = {sgn, 31'd0};
            underflow = 1'b1;
        end else
            result = {sgn, exp_r[7:0], man_r[22:0]};
    end
endmodule

// File: rtl/fp_mult_arbiter.sv
// fp_mult_arbiter: two-requester round-robin front end sharing one FP32 multiplier
// Ports: CLK, nRST (async active-low); req_valid/req_ready/req_data1/req_data2 per requester;
// resp_valid/resp_ready handshake with resp_id, resp_result, resp_overflow, resp_underflow; busy.
// Optional MULT_ARB_STATS_EN adds saturating op_count/exc_count outputs (width CNT_W).
module fp_mult_arbiter
    import fp_mult_arb_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                          CLK,
    input  logic                          nRST,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0][FP_W-1:0]  req_data1,
    input  logic [NUM_REQ-1:0][FP_W-1:0]  req_data2,
    output logic                          resp_valid,
    input  logic                          resp_ready,
    output logic                          resp_id,
    output logic [FP_W-1:0]               resp_result,
    output logic                          resp_overflow,
    output logic                          resp_underflow,
    output logic                          busy
`ifdef MULT_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0]              op_count,
    output logic [CNT_W-1:0]              exc_count
`endif
);
    state_e    state_q, state_d;
    logic      last_grant_q, last_grant_d;
    operand_t  op_q, op_d;
    response_t resp_q, resp_d;
    logic      gnt_id, can_accept, xfer;
    logic [FP_W-1:0] mul_res;
    logic      mul_ovf, mul_unf;
    fp_mult_arbiter_mul u_mul (
        .data1     (op_q.a),
        .data2     (op_q.b),
        .result    (mul_res),
        .overflow  (mul_ovf),
        .underflow (mul_unf)
    );
    always_comb begin
        // both valid: the one not served last; otherwise whichever is valid
        gnt_id       = (&req_valid) ? ~last_grant_q : req_valid[1];
        can_accept   = (state_q == IDLE) || (state_q == HOLD && resp_ready);
        req_ready    = {gnt_id, ~gnt_id} & req_valid & {NUM_REQ{can_accept}};
        xfer         = |req_ready;
        last_grant_d = xfer ? gnt_id : last_grant_q;
        op_d         = xfer ? {gnt_id, req_data1[gnt_id], req_data2[gnt_id]} : op_q;
        resp_d       = (state_q == CALC) ? {op_q.id, mul_ovf, mul_unf, mul_res} : resp_q;
        state_d      = (state_q == CALC) ? HOLD :
                       xfer ? CALC :
                       (state_q == HOLD && !resp_ready) ? HOLD : IDLE;
    end
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            op_q         <= '0;
            resp_q       <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            op_q         <= op_d;
            resp_q       <= resp_d;
        end
    end
    assign resp_valid     = (state_q == HOLD);
    assign busy           = (state_q != IDLE);
    assign resp_id        = resp_q.id;
    assign resp_result    = resp_q.result;
    assign resp_overflow  = resp_q.ovf;
    assign resp_underflow = resp_q.unf;
`ifdef MULT_ARB_STATS_EN
    logic [CNT_W-1:0] op_count_q, op_count_d, exc_count_q, exc_count_d;
    logic             done;
    always_comb begin
        done        = (state_q == HOLD) && resp_ready;
        op_count_d  = (done && !(&op_count_q)) ? op_count_q + CNT_W'(1) : op_count_q;
        exc_count_d = (done && (resp_q.ovf || resp_q.unf) && !(&exc_count_q)) ? exc_count_q + CNT_W'(1) : exc_count_q;
    end
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            op_count_q  <= '0;
            exc_count_q <= '0;
        end else begin
            op_count_q  <= op_count_d;
            exc_count_q <= exc_count_d;
        end
    end
    assign op_count  = op_count_q;
    assign exc_count = exc_count_q;
`endif
endmodule

// File: tb/tb_fp_mult_arbiter.sv
// tb_fp_mult_arbiter: directed self-checking bench for fp_mult_arbiter
module tb_fp_mult_arbiter;
    import fp_mult_arb_pkg::*;
    logic                         CLK = 1'b0;
    logic                         nRST;
    logic [NUM_REQ-1:0]           req_valid, req_ready;
    logic [NUM_REQ-1:0][FP_W-1:0] req_data1, req_data2;
    logic                         resp_valid, resp_ready, resp_id;
    logic [FP_W-1:0]              resp_result;
    logic                         resp_overflow, resp_underflow, busy;
`ifdef MULT_ARB_STATS_EN
    logic [15:0]                  op_count, exc_count;
`endif
    int n_chk = 0;
    int n_bad = 0;
    always #5 CLK = ~CLK;
    fp_mult_arbiter dut (
        .CLK            (CLK),
        .nRST           (nRST),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_data1      (req_data1),
        .req_data2      (req_data2),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_id        (resp_id),
        .resp_result    (resp_result),
        .resp_overflow  (resp_overflow),
        .resp_underflow (resp_underflow),
        .busy           (busy)
`ifdef MULT_ARB_STATS_EN
        ,
        .op_count       (op_count),
        .exc_count      (exc_count)
`endif
    );
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    task automatic tick;
        @(posedge CLK);
        #1;
    endtask
    task automatic do_reset;
        nRST = 1'b0;
        req_valid = '0;
        resp_ready = 1'b0;
        tick;
        tick;
        nRST = 1'b1;
    endtask
    task automatic run_op(input string tag, input logic id, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_r, input logic eo, input logic eu);
        int lat;
        lat = 0;
        req_data1[id] = a;
        req_data2[id] = b;
        req_valid = '0;
        req_valid[id] = 1'b1;
        resp_ready = 1'b1;
        #1;
        chk({tag, "_gnt"}, 32'(req_ready), id ? 32'd2 : 32'd1);
        tick;
        req_valid = '0;
        while (!resp_valid && lat < 8) begin
            tick;
            lat++;
        end
        chk({tag, "_lat"}, 32'(lat), 32'd1);
        chk({tag, "_vld"}, 32'(resp_valid), 32'd1);
        chk({tag, "_res"}, resp_result, exp_r);
        chk({tag, "_id"}, 32'(resp_id), 32'(id));
        chk({tag, "_flg"}, 32'({resp_overflow, resp_underflow}), 32'({eo, eu}));
        tick;
    endtask
    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end
    initial begin
        nRST = 1'b0;
        req_valid = '0;
        resp_ready = 1'b0;
        req_data1 = '0;
        req_data2 = '0;
        #2;
        chk("rst_vld", 32'(resp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_res", resp_result, 32'd0);
        chk("rst_id", 32'(resp_id), 32'd0);
        chk("rst_flg", 32'({resp_overflow, resp_underflow}), 32'd0);
        chk("rst_rdy", 32'(req_ready), 32'd0);
        tick;
        tick;
        nRST = 1'b1;
        run_op("single", 1'b0, 32'h42C86666, 32'h42B50000, 32'h460DB066, 1'b0, 1'b0);
        chk("idle_vld", 32'(resp_valid), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_hold", resp_result, 32'h460DB066);
        do_reset;
        req_data1[0] = 32'hC0ACCCCD;
        req_data2[0] = 32'hC12CCCCD;
        req_data1[1] = 32'h40ACCCCD;
        req_data2[1] = 32'hC12CCCCD;
        req_valid = 2'b11;
        resp_ready = 1'b1;
        #1;
        chk("alt_gnt0", 32'(req_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick;
            chk("alt_calc_vld", 32'(resp_valid), 32'd0);
            chk("alt_calc_rdy", 32'(req_ready), 32'd0);
            tick;
            chk("alt_vld", 32'(resp_valid), 32'd1);
            chk("alt_id", 32'(resp_id), 32'(i % 2));
            chk("alt_res", resp_result, (i % 2 == 1) ? 32'hC26947AF : 32'h426947AF);
            if (i == 3)
                req_valid = '0;
            else
                chk("alt_gnt", 32'(req_ready), (i % 2 == 1) ? 32'd1 : 32'd2);
        end
        tick;
        chk("alt_end_busy", 32'(busy), 32'd0);
        req_data1[0] = 32'h42C86666;
        req_data2[0] = 32'h42B50000;
        req_data1[1] = 32'h40000000;
        req_data2[1] = 32'h40400000;
        resp_ready = 1'b0;
        req_valid = 2'b01;
        tick;
        req_valid = 2'b10;
        tick;
        for (int i = 0; i < 5; i++) begin
            chk("stall_vld", 32'(resp_valid), 32'd1);
            chk("stall_res", resp_result, 32'h460DB066);
            chk("stall_id", 32'(resp_id), 32'd0);
            chk("stall_rdy", 32'(req_ready), 32'd0);
            chk("stall_busy", 32'(busy), 32'd1);
            tick;
        end
        resp_ready = 1'b1;
        #1;
        chk("stall_gnt", 32'(req_ready), 32'd2);
        tick;
        req_valid = '0;
        chk("stall_calc", 32'(resp_valid), 32'd0);
        tick;
        chk("stall2_vld", 32'(resp_valid), 32'd1);
        chk("stall2_id", 32'(resp_id), 32'd1);
        chk("stall2_res", resp_result, 32'h40C00000);
        tick;
        chk("stall_idle", 32'(busy), 32'd0);
        run_op("nan", 1'b1, 32'h40ACCCCD, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0);
        run_op("udf", 1'b0, 32'h00800000, 32'h3F000000, 32'h00000000, 1'b0, 1'b1);
        req_data1[1] = 32'h40000000;
        req_data2[1] = 32'h40400000;
        req_valid = 2'b10;
        tick;
        chk("rcalc_busy", 32'(busy), 32'd1);
        nRST = 1'b0;
        req_valid = '0;
        #1;
        chk("rcalc_busy0", 32'(busy), 32'd0);
        chk("rcalc_vld0", 32'(resp_valid), 32'd0);
        tick;
        nRST = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("rcalc_novld", 32'(resp_valid), 32'd0);
            chk("rcalc_idle", 32'(busy), 32'd0);
        end
        req_valid = 2'b11;
        #1;
        chk("rcalc_first", 32'(req_ready), 32'd1);
        req_valid = '0;
        run_op("n0", 1'b0, 32'hC0ACCCCD, 32'hC12CCCCD, 32'h426947AF, 1'b0, 1'b0);
        run_op("n1", 1'b1, 32'h40ACCCCD, 32'hC12CCCCD, 32'hC26947AF, 1'b0, 1'b0);
        run_op("n2", 1'b0, 32'h40000000, 32'h40400000, 32'h40C00000, 1'b0, 1'b0);
        run_op("ovf", 1'b1, 32'h7F000000, 32'h7F000000, 32'h7F800000, 1'b1, 1'b0);
`ifdef MULT_ARB_STATS_EN
        chk("op_count", 32'(op_count), 32'd4);
        chk("exc_count", 32'(exc_count), 32'd1);
`endif
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
